id0_align: RTL and testbench

- First decode stage; sits between the fetch unit and id1, and is the producer of every *_d1 signal that id1 consumes.
- Accepts 32-bit-aligned fetch words and realigns the mixed 16/32-bit RVC instruction stream in a 3-halfword buffer.
- Pre-decodes branch class, static prediction, rd address and gross illegality.
- Registers one instruction per cycle into the d1 boundary.

---
 rtl/id0_align_if.sv | 10 +
 rtl/id0_align.sv | 172 +++++++++++++++++
 tb/tb_id0_align.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id0_align_if.sv
// Fetch-to-id0 handshake: one 32-bit-aligned fetch word per transfer.
interface id0_align_if;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic [30:0] fetch_pc;
  logic        fetch_ready;

  modport master (output fetch_valid, fetch_data, fetch_pc, input fetch_ready);
  modport slave  (input fetch_valid, fetch_data, fetch_pc, output fetch_ready);
endinterface

// File: rtl/id0_align.sv
// id0_align: realigns the mixed 16/32-bit fetch stream in a 3-halfword buffer,
// pre-decodes branch class / static prediction / rd / illegality, and registers
// one instruction per cycle into the d1 boundary consumed by id1.
module id0_align #(
  parameter int          BufHw   = 3,
  parameter logic [31:0] ResetPc = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  id0_align_if.slave  fetch_bus,
  input  logic        flush_in,
  input  logic        stall_d1,
  output logic        valid_d1,
  output logic        flush_d1,
  output logic [31:0] instr_d1,
  output logic [30:0] pc_d1,
  output logic        compressed_d1,
  output logic        br_d1,
  output logic        br_taken_d1,
  output logic        illegal_d1,
  output logic [4:0]  rd_addr_d1
);

  logic [15:0] hw_buf  [BufHw];
  logic [15:0] buf_nxt [BufHw];
  logic [1:0]  buf_cnt, cnt_left, cnt_nxt, head_len, take;
  logic [30:0] head_pc, pc_nxt;
  logic        head_comp, head_ok, issue, accept, ready;
  logic [31:0] cand;
  logic [7:0]  pd;

  // Returns {br, taken, illegal, rd[4:0]} for the head instruction.
  function automatic logic [7:0] pre_decode(input logic [31:0] ins, input logic comp);
    logic       br, tk, ill;
    logic [4:0] rd;
    logic [2:0] f3;
    br  = 1'b0;
    tk  = 1'b0;
    ill = 1'b0;
    rd  = 5'd0;
    f3  = ins[15:13];
    if (comp) begin
      ill = (ins[15:0] == 16'h0000);
      case (ins[1:0])
        2'b00: if (f3 == 3'b000 || f3 == 3'b010) rd = {2'b01, ins[4:2]};
        2'b01: begin
          case (f3)
            3'b000, 3'b010, 3'b011: rd = ins[11:7];
            3'b001: begin br = 1'b1; tk = 1'b1; rd = 5'd1; end  // c.jal links x1
            3'b100: rd = {2'b01, ins[9:7]};
            3'b101: begin br = 1'b1; tk = 1'b1; end
            3'b110, 3'b111: begin br = 1'b1; tk = ins[12]; end  // backward taken
            default: ;
          endcase
        end
        2'b10: begin
          if (f3 == 3'b000 || f3 == 3'b010) begin
            rd = ins[11:7];
          end else if (f3 == 3'b100) begin
            if (ins[6:2] != 5'd0) begin
              rd = ins[11:7];
            end else begin
              rd = {4'd0, ins[12]};
              if (ins[11:7] != 5'd0) begin  // c.jr / c.jalr
                br = 1'b1;
                tk = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end else begin
      ill = (ins[4:2] == 3'b111) || (ins == 32'hFFFF_FFFF);
      case (ins[6:0])
        7'b1100011: begin br = 1'b1; tk = ins[31]; end
        7'b1101111, 7'b1100111: begin br = 1'b1; tk = 1'b1; rd = ins[11:7]; end
        7'b0100011: rd = 5'd0;
        default: rd = ins[11:7];
      endcase
    end
    return {br, tk, ill, rd};
  endfunction

  assign ready = (buf_cnt <= 2'd1);
  assign fetch_bus.fetch_ready = ready;

  // Head completeness, consume/shift, enqueue and head-pc update.
  always_comb begin
    head_comp = (hw_buf[0][1:0] != 2'b11);
    head_len  = head_comp ? 2'd1 : 2'd2;
    head_ok   = (buf_cnt >= head_len);
    issue     = !stall_d1 && !flush_in && head_ok;
    take      = issue ? head_len : 2'd0;
    cnt_left  = buf_cnt - take;
    accept    = fetch_bus.fetch_valid && ready && !flush_in;
    cand      = head_comp ? {16'h0000, hw_buf[0]} : {hw_buf[1], hw_buf[0]};
    pd        = pre_decode(cand, head_comp);
    buf_nxt   = hw_buf;
    if (take == 2'd1) begin
      buf_nxt[0] = hw_buf[1];
      buf_nxt[1] = hw_buf[2];
    end else if (take == 2'd2) begin
      buf_nxt[0] = hw_buf[2];
    end
    cnt_nxt = cnt_left;
    pc_nxt  = head_pc + {29'd0, take};
    if (accept) begin
      if (cnt_left == 2'd0) pc_nxt = fetch_bus.fetch_pc;
      // fetch_pc[0] is pc[1]: only the upper halfword belongs to the stream
      if (fetch_bus.fetch_pc[0]) begin
        buf_nxt[cnt_left] = fetch_bus.fetch_data[31:16];
        cnt_nxt           = cnt_left + 2'd1;
      end else begin
        buf_nxt[cnt_left]        = fetch_bus.fetch_data[15:0];
        buf_nxt[cnt_left + 2'd1] = fetch_bus.fetch_data[31:16];
        cnt_nxt                  = cnt_left + 2'd2;
      end
    end
    if (flush_in) cnt_nxt = 2'd0;
  end

  // Buffer occupancy and head pc.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_cnt <= 2'd0;
      head_pc <= ResetPc[31:1];
    end else begin
      buf_cnt <= cnt_nxt;
      head_pc <= pc_nxt;
    end
  end

  // Halfword storage; contents are qualified by buf_cnt.
  always_ff @(posedge clk) begin
    hw_buf <= buf_nxt;
  end

  // d1 boundary registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_d1      <= 1'b0;
      flush_d1      <= 1'b0;
      instr_d1      <= 32'd0;
      pc_d1         <= 31'd0;
      compressed_d1 <= 1'b0;
      br_d1         <= 1'b0;
      br_taken_d1   <= 1'b0;
      illegal_d1    <= 1'b0;
      rd_addr_d1    <= 5'd0;
    end else begin
      flush_d1 <= flush_in;
      if (flush_in) begin
        valid_d1 <= 1'b0;
      end else if (!stall_d1) begin
        if (head_ok) begin
          valid_d1      <= 1'b1;
          instr_d1      <= cand;
          pc_d1         <= head_pc;
          compressed_d1 <= head_comp;
          br_d1         <= pd[7];
          br_taken_d1   <= pd[6];
          illegal_d1    <= pd[5];
          rd_addr_d1    <= pd[4:0];
        end else begin
          valid_d1 <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_id0_align.sv
// Bench for id0_align: directed scenarios plus randomized fetch traffic, all
// compared each cycle against a halfword-queue reference model.
module tb_id0_align;
  logic        clk = 1'b0;
  logic        rst_n, flush_in, stall_d1;
  logic        valid_d1, flush_d1, compressed_d1, br_d1, br_taken_d1, illegal_d1;
  logic [31:0] instr_d1;
  logic [30:0] pc_d1;
  logic [4:0]  rd_addr_d1;
  int          n_checks = 0;
  int          n_fail   = 0;

  id0_align_if fif ();

  id0_align #(.BufHw(3), .ResetPc(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_bus(fif), .flush_in(flush_in), .stall_d1(stall_d1),
    .valid_d1(valid_d1), .flush_d1(flush_d1), .instr_d1(instr_d1), .pc_d1(pc_d1),
    .compressed_d1(compressed_d1), .br_d1(br_d1), .br_taken_d1(br_taken_d1),
    .illegal_d1(illegal_d1), .rd_addr_d1(rd_addr_d1)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [15:0] mq[$];
  logic [30:0] mpc;
  bit          e_valid, e_flush, e_comp, e_br, e_tk, e_ill;
  logic [31:0] e_instr;
  logic [30:0] e_pc;
  logic [4:0]  e_rd;
  bit          m_acc;
  bit          chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Classify by instruction name and derive the pre-decode fields.
  function automatic logic [7:0] ref_decode(input logic [31:0] ins, input bit comp);
    bit          br, tk, ill;
    logic [4:0]  rd;
    logic [15:0] h;
    bit          is_bc, is_jal, is_jalr, is_st;
    br = 0; tk = 0; ill = 0; rd = 5'd0; h = ins[15:0];
    if (!comp) begin
      is_bc   = (ins[6:0] == 7'h63);
      is_jal  = (ins[6:0] == 7'h6F);
      is_jalr = (ins[6:0] == 7'h67);
      is_st   = (ins[6:0] == 7'h23);
      br  = is_bc || is_jal || is_jalr;
      tk  = is_jal || is_jalr || (is_bc && ins[31]);
      rd  = (is_bc || is_st) ? 5'd0 : ins[11:7];
      ill = (ins[4:2] == 3'b111) || (ins == 32'hFFFF_FFFF);
    end else begin
      ill = (h == 16'h0000);
      case ({h[1:0], h[15:13]})
        5'b01_001: begin br = 1; tk = 1; rd = 5'd1; end          // c.jal
        5'b01_101: begin br = 1; tk = 1; end                     // c.j
        5'b01_110, 5'b01_111: begin br = 1; tk = h[12]; end      // c.beqz/c.bnez
        5'b01_000, 5'b01_010, 5'b01_011: rd = h[11:7];
        5'b01_100: rd = {2'b01, h[9:7]};
        5'b00_000, 5'b00_010: rd = {2'b01, h[4:2]};
        5'b10_000, 5'b10_010: rd = h[11:7];
        5'b10_100: begin
          if (h[6:2] != 0) rd = h[11:7];
          else begin
            rd = h[12] ? 5'd1 : 5'd0;
            if (h[11:7] != 0) begin br = 1; tk = 1; end         // c.jr/c.jalr
          end
        end
        default: ;
      endcase
    end
    return {br, tk, ill, rd};
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [31:0] ins;
    logic [7:0]  dec;
    bit          comp, rdy;
    int          n;
    m_acc = 0;
    if (!rst_n) begin
      mq.delete(); mpc = '0;
      e_valid = 0; e_flush = 0; e_instr = '0; e_pc = '0; e_comp = 0;
      e_br = 0; e_tk = 0; e_ill = 0; e_rd = '0;
      return;
    end
    rdy = (mq.size() <= 1);
    e_flush = flush_in;
    if (flush_in) begin
      mq.delete();
      e_valid = 0;
      return;
    end
    if (!stall_d1) begin
      n = 0;
      if (mq.size() >= 1) n = (mq[0][1:0] == 2'b11) ? 2 : 1;
      if (n > 0 && mq.size() >= n) begin
        comp = (n == 1);
        ins  = comp ? {16'h0000, mq[0]} : {mq[1], mq[0]};
        dec  = ref_decode(ins, comp);
        e_valid = 1; e_instr = ins; e_pc = mpc; e_comp = comp;
        {e_br, e_tk, e_ill, e_rd} = dec;
        for (int k = 0; k < n; k++) void'(mq.pop_front());
        mpc = mpc + 31'(n);
      end else begin
        e_valid = 0;
      end
    end
    if (fif.fetch_valid && rdy) begin
      m_acc = 1;
      if (mq.size() == 0) mpc = fif.fetch_pc;
      if (!fif.fetch_pc[0]) mq.push_back(fif.fetch_data[15:0]);
      mq.push_back(fif.fetch_data[31:16]);
    end
  endtask

  task automatic compare_all();
    chk("ready",    32'(fif.fetch_ready),  32'(mq.size() <= 1));
    chk("valid_d1", 32'(valid_d1),         32'(e_valid));
    chk("flush_d1", 32'(flush_d1),         32'(e_flush));
    chk("instr_d1", instr_d1,              e_instr);
    chk("pc_d1",    32'(pc_d1),            32'(e_pc));
    chk("comp_d1",  32'(compressed_d1),    32'(e_comp));
    chk("br_d1",    32'(br_d1),            32'(e_br));
    chk("taken_d1", 32'(br_taken_d1),      32'(e_tk));
    chk("ill_d1",   32'(illegal_d1),       32'(e_ill));
    chk("rd_d1",    32'(rd_addr_d1),       32'(e_rd));
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [30:0] pc);
    bit got;
    got = 0;
    fif.fetch_valid = 1'b1; fif.fetch_data = d; fif.fetch_pc = pc;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_acc) begin got = 1; break; end
    end
    chk("send_accept", 32'(got), 32'd1);
    fif.fetch_valid = 1'b0;
  endtask

  function automatic logic [15:0] rand_hw();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: op = 7'h63;
      1: op = 7'h6F;
      2: op = 7'h67;
      3: op = 7'h23;
      4: op = 7'h13;
      5: op = 7'h1F;
      default: op = 7'h33;
    endcase
    case ($urandom_range(0, 9))
      0: return 16'h0000;
      1: return {r[15:2], 2'b01};
      2: return {3'b100, r[12:2], 2'b10};
      3: return {3'b100, r[12], r[11:7], 5'd0, 2'b10};
      4: return {r[15:2], 2'b00};
      5, 6: return {r[15:7], op};
      7: return 16'hFFFF;
      default: return r[15:0];
    endcase
  endfunction

  logic [31:0] wd;
  logic [30:0] fpc;
  logic [31:0] tmp;
  bit          have;

  initial begin
    rst_n = 1'b0; flush_in = 1'b0; stall_d1 = 1'b0;
    fif.fetch_valid = 1'b0; fif.fetch_data = '0; fif.fetch_pc = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("rst_valid", 32'(valid_d1), 32'd0);
    chk("rst_instr", instr_d1, 32'd0);

    // aligned 32-bit addi a0
    send(32'h0000_0513, 31'h0);
    tick();
    chk("t1_valid", 32'(valid_d1), 32'd1);
    chk("t1_instr", instr_d1, 32'h0000_0513);
    chk("t1_rd", 32'(rd_addr_d1), 32'd10);
    chk("t1_pc", 32'(pc_d1), 32'd0);

    // two compressed in one word
    send(32'h4505_4501, 31'h0);
    tick();
    chk("t2a_instr", instr_d1, 32'h0000_4501);
    chk("t2a_comp", 32'(compressed_d1), 32'd1);
    tick();
    chk("t2b_instr", instr_d1, 32'h0000_4505);
    chk("t2b_pc", 32'(pc_d1), 32'd1);

    // 32-bit instruction straddling two words
    send(32'h0513_4501, 31'h10);
    send(32'h0000_0000, 31'h12);
    tick();
    chk("t3_instr", instr_d1, 32'h0000_0513);
    chk("t3_pc", 32'(pc_d1), 32'h11);
    tick();
    chk("t3_ill", 32'(illegal_d1), 32'd1);

    // branches
    send(32'hFE00_0EE3, 31'h40);
    tick();
    chk("beq_br", 32'(br_d1), 32'd1);
    chk("beq_tk", 32'(br_taken_d1), 32'd1);
    send(32'h0000_1463, 31'h50);
    tick();
    chk("bne_tk", 32'(br_taken_d1), 32'd0);
    send(32'h0001_A001, 31'h60);
    tick();
    chk("cj_tk", 32'(br_taken_d1), 32'd1);
    tick();
    chk("cnop_br", 32'(br_d1), 32'd0);

    // flush while stalled with two halfwords buffered
    stall_d1 = 1'b1;
    send(32'h4505_4501, 31'h80);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0; stall_d1 = 1'b0;
    chk("fl_valid", 32'(valid_d1), 32'd0);
    chk("fl_flush", 32'(flush_d1), 32'd1);
    send(32'h4509_FFFF, 31'h91);
    chk("fl_flush_clr", 32'(flush_d1), 32'd0);
    tick();
    chk("fl_instr", instr_d1, 32'h0000_4509);
    chk("fl_pc", 32'(pc_d1), 32'h91);

    // illegal compressed zero halfword
    send(32'h0000_0000, 31'hA0);
    tick();
    chk("ill_c", 32'(illegal_d1), 32'd1);
    tick();

    // reset mid-stream
    send(32'h4505_4501, 31'hB0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid", 32'(valid_d1), 32'd0);
    chk("mrst_pc", 32'(pc_d1), 32'd0);
    send(32'h0000_0593, 31'hC0);
    tick();
    chk("mrst_instr", instr_d1, 32'h0000_0593);
    chk("mrst_pc2", 32'(pc_d1), 32'hC0);

    // randomized traffic
    have = 0;
    fpc  = 31'h100;
    for (int c = 0; c < 4000; c++) begin
      if (!have) begin
        wd = {rand_hw(), rand_hw()};
        have = 1;
      end
      fif.fetch_valid = ($urandom_range(0, 9) < 7);
      fif.fetch_data  = wd;
      fif.fetch_pc    = fpc;
      stall_d1 = ($urandom_range(0, 9) < 2);
      flush_in = ($urandom_range(0, 49) == 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      tick();
      if (!rst_n || flush_in) begin
        tmp  = $urandom;
        fpc  = tmp[30:0];
        have = 0;
      end else if (m_acc) begin
        fpc  = {fpc[30:1], 1'b0} + 31'd2;
        have = 0;
      end
    end
    rst_n = 1'b1; flush_in = 1'b0; stall_d1 = 1'b0; fif.fetch_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
